// File: rtl/interrupt_acknowledge_sequencer.sv
// CPU-side INTA sequencer: synchronizes the PIC interrupt, issues the two-pulse
// active-low acknowledge, captures the vector and offers it over valid/ready.
module interrupt_acknowledge_sequencer #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       INTERRUPT,
  input  logic       INTERRUPT_ENABLE,
  output logic       INTERRUPT_ACKNOWLEDGE,
  input  logic [7:0] DATA_BUS_IN,
  output logic [7:0] VECTOR,
  output logic       VECTOR_SPURIOUS,
  output logic       VECTOR_VALID,
  input  logic       VECTOR_READY,
  output logic       BUSY
);

  localparam int MAX_CYC = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] LOW_LOAD = CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(INTA_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE1,
    S_GAP,
    S_PULSE2,
    S_HOLD
  } state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic            r_sync1, r_sync2;
  logic            r_inta, w_inta_nx;
  logic [7:0]      r_vector, w_vector_nx;
  logic            r_spur, w_spur_nx;
  logic            r_valid, w_valid_nx;
  logic            r_spur_flag, w_spur_flag_nx;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= INTERRUPT;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_inta      <= 1'b1;
      r_vector    <= '0;
      r_spur      <= 1'b0;
      r_valid     <= 1'b0;
      r_spur_flag <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_inta      <= w_inta_nx;
      r_vector    <= w_vector_nx;
      r_spur      <= w_spur_nx;
      r_valid     <= w_valid_nx;
      r_spur_flag <= w_spur_flag_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_inta_nx      = r_inta;
    w_vector_nx    = r_vector;
    w_spur_nx      = r_spur;
    w_valid_nx     = r_valid;
    w_spur_flag_nx = r_spur_flag;
    unique case (r_state)
      S_IDLE: begin
        if (r_sync2 && INTERRUPT_ENABLE) begin
          w_state_nx = S_PULSE1;
          w_inta_nx  = 1'b0;
          w_cnt_nx   = LOW_LOAD;
        end
      end
      S_PULSE1: begin
        // Interrupt still present at the end of pulse 1 decides spuriousness
        if (r_cnt == '0) begin
          w_state_nx     = S_GAP;
          w_inta_nx      = 1'b1;
          w_cnt_nx       = GAP_LOAD;
          w_spur_flag_nx = ~r_sync2;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nx = S_PULSE2;
          w_inta_nx  = 1'b0;
          w_cnt_nx   = LOW_LOAD;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      S_PULSE2: begin
        if (r_cnt == '0) begin
          w_state_nx  = S_HOLD;
          w_inta_nx   = 1'b1;
          w_vector_nx = DATA_BUS_IN;
          w_spur_nx   = r_spur_flag;
          w_valid_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (VECTOR_READY) begin
          w_state_nx = S_IDLE;
          w_valid_nx = 1'b0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign INTERRUPT_ACKNOWLEDGE = r_inta;
  assign VECTOR                = r_vector;
  assign VECTOR_SPURIOUS       = r_spur;
  assign VECTOR_VALID          = r_valid;
  assign BUSY                  = (r_state != S_IDLE);

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Self-checking bench for interrupt_acknowledge_sequencer (default parameters):
// edge-by-edge acknowledge waveform checks plus a vector scoreboard.
module tb_interrupt_acknowledge_sequencer;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       INTERRUPT;
  logic       INTERRUPT_ENABLE;
  logic       INTERRUPT_ACKNOWLEDGE;
  logic [7:0] DATA_BUS_IN;
  logic [7:0] VECTOR;
  logic       VECTOR_SPURIOUS;
  logic       VECTOR_VALID;
  logic       VECTOR_READY;
  logic       BUSY;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_pushed = 0;
  int unsigned n_popped = 0;

  logic [8:0] sb_q[$];
  logic       r_prev_valid = 1'b0;

  // Acknowledge level after each edge, starting from the edge that leaves IDLE
  bit exp_inta[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  interrupt_acknowledge_sequencer #(
    .INTA_LOW_CYCLES(2),
    .INTA_GAP_CYCLES(2)
  ) dut (
    .CLOCK                 (CLOCK),
    .RESET                 (RESET),
    .INTERRUPT             (INTERRUPT),
    .INTERRUPT_ENABLE      (INTERRUPT_ENABLE),
    .INTERRUPT_ACKNOWLEDGE (INTERRUPT_ACKNOWLEDGE),
    .DATA_BUS_IN           (DATA_BUS_IN),
    .VECTOR                (VECTOR),
    .VECTOR_SPURIOUS       (VECTOR_SPURIOUS),
    .VECTOR_VALID          (VECTOR_VALID),
    .VECTOR_READY          (VECTOR_READY),
    .BUSY                  (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Expects the next edge to be the one that leaves IDLE; returns after the capture edge.
  task automatic run_seq(input logic [7:0] d, input logic sp, input bit drop);
    if (drop) INTERRUPT = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("inta_e%0d", i), 32'(INTERRUPT_ACKNOWLEDGE), 32'(exp_inta[i]));
      check($sformatf("valid_e%0d", i), 32'(VECTOR_VALID), (i == 6) ? 32'd1 : 32'd0);
      if (i == 0) check("busy_start", 32'(BUSY), 32'd1);
      if (i == 3) begin
        DATA_BUS_IN = d;
        sb_q.push_back({sp, d});
        n_pushed++;
      end
    end
    check("vector", 32'(VECTOR), 32'(d));
    check("spurious", 32'(VECTOR_SPURIOUS), 32'(sp));
  endtask

  always @(negedge CLOCK) begin
    if (VECTOR_VALID && !r_prev_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", 32'(VECTOR_VALID), 32'd0);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        n_popped++;
        check("sb_vector", 32'(VECTOR), 32'(e[7:0]));
        check("sb_spurious", 32'(VECTOR_SPURIOUS), 32'(e[8]));
      end
    end
    r_prev_valid <= VECTOR_VALID;
  end

  initial begin
    RESET            = 1'b1;
    INTERRUPT        = 1'b1;
    INTERRUPT_ENABLE = 1'b1;
    VECTOR_READY     = 1'b1;
    DATA_BUS_IN      = 8'h00;

    // Reset held for 3 edges with the interrupt present
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_inta", 32'(INTERRUPT_ACKNOWLEDGE), 32'd1);
      check("rst_valid", 32'(VECTOR_VALID), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_vector", 32'(VECTOR), 32'h00);
      check("rst_spur", 32'(VECTOR_SPURIOUS), 32'd0);
    end
    RESET = 1'b0;

    // Nominal: edges k and k+1 only fill the synchronizer
    step();
    check("k0_inta", 32'(INTERRUPT_ACKNOWLEDGE), 32'd1);
    check("k0_busy", 32'(BUSY), 32'd0);
    step();
    check("k1_inta", 32'(INTERRUPT_ACKNOWLEDGE), 32'd1);
    check("k1_busy", 32'(BUSY), 32'd0);
    run_seq(8'hA9, 1'b0, 1'b0);
    step();
    check("nom_valid_drop", 32'(VECTOR_VALID), 32'd0);
    check("nom_busy_idle", 32'(BUSY), 32'd0);
    check("nom_vector_hold", 32'(VECTOR), 32'hA9);

    // Backpressure: interrupt still high, so the next sequence starts at once
    VECTOR_READY = 1'b0;
    run_seq(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 32'(VECTOR_VALID), 32'd1);
      check("bp_vector", 32'(VECTOR), 32'h5A);
      check("bp_inta", 32'(INTERRUPT_ACKNOWLEDGE), 32'd1);
      check("bp_busy", 32'(BUSY), 32'd1);
      if (i == 2) DATA_BUS_IN = 8'h11;
    end
    VECTOR_READY = 1'b1;
    step();
    check("bp_xfer_valid", 32'(VECTOR_VALID), 32'd0);
    check("bp_xfer_inta", 32'(INTERRUPT_ACKNOWLEDGE), 32'd1);
    check("bp_xfer_vector", 32'(VECTOR), 32'h5A);

    // Spurious: interrupt withdrawn so the synchronized level is 0 at end of pulse 1
    run_seq(8'hAF, 1'b1, 1'b1);
    step();
    check("sp_valid_drop", 32'(VECTOR_VALID), 32'd0);
    check("sp_busy_idle", 32'(BUSY), 32'd0);

    // Enable gating
    INTERRUPT_ENABLE = 1'b0;
    INTERRUPT        = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("gate_inta", 32'(INTERRUPT_ACKNOWLEDGE), 32'd1);
      check("gate_busy", 32'(BUSY), 32'd0);
    end
    INTERRUPT_ENABLE = 1'b1;
    run_seq(8'h77, 1'b0, 1'b0);
    step();
    check("gate_valid_drop", 32'(VECTOR_VALID), 32'd0);

    // Reset mid-sequence: follow-on sequence starts, abort it in pulse 2
    for (int i = 0; i < 5; i++) step();
    check("mid_pulse2_inta", 32'(INTERRUPT_ACKNOWLEDGE), 32'd0);
    check("mid_pulse2_busy", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    step();
    check("mid_rst_inta", 32'(INTERRUPT_ACKNOWLEDGE), 32'd1);
    check("mid_rst_valid", 32'(VECTOR_VALID), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    RESET     = 1'b0;
    INTERRUPT = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("post_rst_valid", 32'(VECTOR_VALID), 32'd0);
      check("post_rst_inta", 32'(INTERRUPT_ACKNOWLEDGE), 32'd1);
    end

    check("sb_left", 32'(sb_q.size()), 32'd0);
    check("sb_count", 32'(n_popped), 32'(n_pushed));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
